// File: rtl/pueo_beam_pkg.sv
// Shared constants and helpers for the per-beam power trigger datapath.
package pueo_beam_pkg;

    localparam int DEF_NSAMP  = 8;
    localparam int DEF_SQBITS = 14;
    localparam int CNTBITS    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } trigState_t;

    // Accumulator width that can hold NWIN clocks of NSAMP full-scale squares.
    function automatic int accBits(input int nsamp, input int sqbits, input int nwin);
        return sqbits + $clog2(nsamp) + $clog2(nwin);
    endfunction

endpackage

// File: rtl/beam_power_boxcar.sv
// Per-clock sum of squares followed by an NWIN-clock boxcar integrator and a
// fill tracker that marks when the window holds only valid data.
module beam_power_boxcar
    import pueo_beam_pkg::*;
#(
    parameter int NSAMP  = DEF_NSAMP,
    parameter int SQBITS = DEF_SQBITS,
    parameter int NWIN   = 4,
    localparam int ACCBITS = accBits(NSAMP, SQBITS, NWIN)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NSAMP*SQBITS-1:0] sq_i,
    input  logic                    sq_valid_i,
    output logic [ACCBITS-1:0]      power_o,
    output logic                    power_vld_o
);

    localparam int SUMBITS  = SQBITS + $clog2(NSAMP);
    localparam int FILLBITS = $clog2(NWIN + 1);

    logic [NSAMP*SQBITS-1:0] sq_p0;
    logic                    vld_p0;
    logic [SUMBITS-1:0]      sumNext;
    logic [SUMBITS-1:0]      sum_p1;
    logic                    vld_p1;
    logic [SUMBITS-1:0]      dly_p2 [NWIN];
    logic [ACCBITS-1:0]      acc_p2;
    logic [FILLBITS-1:0]     fill_p2;

    // Invalid clocks contribute zero so the window keeps sliding.
    always_comb begin
        sumNext = '0;
        if (vld_p0) begin
            for (int k = 0; k < NSAMP; k++) begin
                sumNext = sumNext + SUMBITS'(sq_p0[SQBITS*k +: SQBITS]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sq_p0   <= '0;
            vld_p0  <= 1'b0;
            sum_p1  <= '0;
            vld_p1  <= 1'b0;
            acc_p2  <= '0;
            fill_p2 <= '0;
            for (int k = 0; k < NWIN; k++) begin
                dly_p2[k] <= '0;
            end
        end else begin
            // C0: input capture
            sq_p0  <= sq_i;
            vld_p0 <= sq_valid_i;
            // C1: sum of squares
            sum_p1 <= sumNext;
            vld_p1 <= vld_p0;
            // C2: running boxcar; oldest term leaves as the newest enters
            acc_p2    <= acc_p2 + ACCBITS'(sum_p1) - ACCBITS'(dly_p2[NWIN-1]);
            dly_p2[0] <= sum_p1;
            for (int k = 1; k < NWIN; k++) begin
                dly_p2[k] <= dly_p2[k-1];
            end
            if (!vld_p1) begin
                fill_p2 <= '0;
            end else if (fill_p2 != FILLBITS'(NWIN)) begin
                fill_p2 <= fill_p2 + 1'b1;
            end
        end
    end

    assign power_o     = acc_p2;
    assign power_vld_o = (fill_p2 == FILLBITS'(NWIN));

endmodule

// File: rtl/beam_power_trigger.sv
// Per-beam power trigger: boxcar power vs. runtime threshold, one-clock trigger
// pulse with holdoff, and a saturating trigger counter.
module beam_power_trigger
    import pueo_beam_pkg::*;
#(
    parameter int NSAMP   = DEF_NSAMP,
    parameter int SQBITS  = DEF_SQBITS,
    parameter int NWIN    = 4,
    parameter int HOLDOFF = 16,
    localparam int ACCBITS = accBits(NSAMP, SQBITS, NWIN)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NSAMP*SQBITS-1:0] sq_i,
    input  logic                    sq_valid_i,
    input  logic [ACCBITS-1:0]      thresh_i,
    input  logic                    thresh_wr_i,
    output logic                    thresh_ack_o,
    input  logic                    cnt_clr_i,
    output logic [ACCBITS-1:0]      power_o,
    output logic                    power_vld_o,
    output logic                    trig_o,
    output logic [CNTBITS-1:0]      trig_count_o
);

    localparam int HOLDBITS = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    trigState_t           state;
    logic [HOLDBITS-1:0]  holdCnt;
    logic [ACCBITS-1:0]   threshReg;

    function automatic logic [CNTBITS-1:0] satInc(input logic [CNTBITS-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    beam_power_boxcar #(
        .NSAMP (NSAMP),
        .SQBITS(SQBITS),
        .NWIN  (NWIN)
    ) boxcar (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sq_i       (sq_i),
        .sq_valid_i (sq_valid_i),
        .power_o    (power_o),
        .power_vld_o(power_vld_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            threshReg    <= '1;
            thresh_ack_o <= 1'b0;
            state        <= IDLE;
            holdCnt      <= '0;
            trig_o       <= 1'b0;
            trig_count_o <= '0;
        end else begin
            thresh_ack_o <= thresh_wr_i;
            if (thresh_wr_i) begin
                threshReg <= thresh_i;
            end

            // C3: trigger decision on the registered power
            case (state)
                IDLE: begin
                    if (power_vld_o && (power_o > threshReg)) begin
                        trig_o  <= 1'b1;
                        state   <= HOLD;
                        holdCnt <= HOLDBITS'(HOLDOFF - 1);
                    end else begin
                        trig_o <= 1'b0;
                    end
                end
                HOLD: begin
                    trig_o <= 1'b0;
                    if (holdCnt == '0) begin
                        state <= IDLE;
                    end else begin
                        holdCnt <= holdCnt - 1'b1;
                    end
                end
            endcase

            // A clear landing on the trigger pulse still counts that trigger.
            if (trig_o) begin
                trig_count_o <= cnt_clr_i ? CNTBITS'(1) : satInc(trig_count_o);
            end else if (cnt_clr_i) begin
                trig_count_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_beam_power_trigger.sv
// Scoreboard bench: a windowed-sum reference model predicts every output each
// clock; a separate monitor pops and compares on the falling edge.
module tb_beam_power_trigger;

    localparam int NSAMP   = 8;
    localparam int SQBITS  = 14;
    localparam int NWIN    = 4;
    localparam int HOLDOFF = 16;
    localparam int ACC     = SQBITS + $clog2(NSAMP) + $clog2(NWIN);
    localparam int MAXC    = 6000;
    localparam longint THR_ONES = (longint'(1) << ACC) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NSAMP*SQBITS-1:0] sq;
    logic                    sqValid;
    logic [ACC-1:0]          thresh;
    logic                    threshWr;
    logic                    threshAck;
    logic                    cntClr;
    logic [ACC-1:0]          power;
    logic                    powerVld;
    logic                    trig;
    logic [15:0]             trigCount;

    always #5 clk = ~clk;

    beam_power_trigger #(
        .NSAMP  (NSAMP),
        .SQBITS (SQBITS),
        .NWIN   (NWIN),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sq_i        (sq),
        .sq_valid_i  (sqValid),
        .thresh_i    (thresh),
        .thresh_wr_i (threshWr),
        .thresh_ack_o(threshAck),
        .cnt_clr_i   (cntClr),
        .power_o     (power),
        .power_vld_o (powerVld),
        .trig_o      (trig),
        .trig_count_o(trigCount)
    );

    typedef struct {
        int     n;
        longint power;
        bit     pvld;
        bit     trig;
        int     cnt;
        bit     ack;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference history, indexed by clock edge.
    longint sA   [MAXC];
    bit     vA   [MAXC];
    longint pA   [MAXC];
    bit     pvA  [MAXC];
    longint thrA [MAXC];
    bit     tgA  [MAXC];
    int     cyc      = 0;
    int     lastR    = -1;
    int     lastTrig = -1;
    int     cnt      = 0;
    longint curThr   = THR_ONES;

    // sqv >= 0: every sample equals sqv; sqv < 0: each sample random in 0..-sqv.
    task automatic step(input bit r, input bit v, input int sqv, input bit w,
                        input longint t, input bit c);
        longint sum;
        longint p;
        bit     pv;
        bit     tg;
        int     n;
        int     val;
        exp_t   e;
        n = cyc;
        if (n >= MAXC) begin
            $display("FAIL stimulus_overrun cyc=%0d limit=%0d", n, MAXC);
            $fatal(1, "stimulus table overrun");
        end
        sum = 0;
        for (int k = 0; k < NSAMP; k++) begin
            val = (sqv >= 0) ? sqv : int'($urandom_range(0, -sqv));
            sq[SQBITS*k +: SQBITS] = SQBITS'(val);
            sum += val;
        end
        rst = r; sqValid = v; threshWr = w; thresh = ACC'(t); cntClr = c;

        sA[n] = sum;
        vA[n] = v;
        if (r) lastR = n;
        if (r) curThr = THR_ONES;
        else if (w) curThr = t;
        // Window after edge n holds inputs n-2 .. n-1-NWIN that arrived after the last reset.
        p = 0;
        pv = 1'b1;
        for (int k = 2; k <= NWIN + 1; k++) begin
            int i;
            i = n - k;
            if (i > lastR && i >= 0) begin
                if (vA[i]) p += sA[i];
                else pv = 1'b0;
            end else begin
                pv = 1'b0;
            end
        end
        tg = 1'b0;
        if (r) lastTrig = -1;
        else if (n > 0 && (lastTrig < 0 || n - lastTrig > HOLDOFF) &&
                 pvA[n-1] && pA[n-1] > thrA[n-1]) begin
            tg = 1'b1;
            lastTrig = n;
        end
        if (r) cnt = 0;
        else if (n > 0 && tgA[n-1]) cnt = c ? 1 : ((cnt == 65535) ? 65535 : cnt + 1);
        else if (c) cnt = 0;
        pA[n] = p; pvA[n] = pv; thrA[n] = curThr; tgA[n] = tg;

        e.n = n; e.power = p; e.pvld = pv; e.trig = tg; e.cnt = cnt; e.ack = !r && w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input int n, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", nm, n, act, req);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("power",     e.n, 32'(power),     32'(e.power));
                chk("power_vld", e.n, 32'(powerVld),  32'(e.pvld));
                chk("trig",      e.n, 32'(trig),      32'(e.trig));
                chk("trig_count",e.n, 32'(trigCount), 32'(e.cnt));
                chk("thresh_ack",e.n, 32'(threshAck), 32'(e.ack));
            end
        end
    end

    initial begin
        bit done;
        rst = 1'b1; sq = '0; sqValid = 1'b0; thresh = '0; threshWr = 1'b0; cntClr = 1'b0;
        repeat (3) step(1, 0, 0, 0, 0, 0);

        // Continuous 100s over threshold 3199: periodic triggers.
        step(0, 0, 0, 1, 3199, 0);
        repeat (60) step(0, 1, 100, 0, 0, 0);

        // Threshold raised to 5000 while holding off.
        done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            bit w;
            w = !done && tgA[cyc-1];
            if (w) done = 1'b1;
            step(0, 1, 100, w, 5000, 0);
        end

        // Equal to threshold never triggers.
        step(0, 1, 100, 1, 3200, 0);
        repeat (40) step(0, 1, 100, 0, 0, 0);

        // Single full-scale valid clock among invalid zeros.
        step(0, 0, 0, 1, 0, 0);
        repeat (8) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 16383, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0, 0);

        // Valid gap mid-run.
        step(0, 0, 0, 1, 3199, 0);
        repeat (30) step(0, 1, 100, 0, 0, 0);
        step(0, 0, 100, 0, 0, 0);
        repeat (30) step(0, 1, 100, 0, 0, 0);

        // Reset mid-window, then clear coincident with trigger pulses.
        repeat (3) step(0, 1, 100, 0, 0, 0);
        step(1, 1, 100, 0, 0, 0);
        step(0, 0, 0, 1, 3199, 0);
        repeat (20) step(0, 1, 100, 0, 0, 0);
        for (int i = 0; i < 80; i++) step(0, 1, 100, 0, 0, tgA[cyc-1]);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            bit r, v, w, c;
            int sqv;
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 19) != 0);
            sqv = ($urandom_range(0, 49) == 0) ? -16383 : -200;
            w   = ($urandom_range(0, 29) == 0);
            c   = ($urandom_range(0, 59) == 0) || (tgA[cyc-1] && $urandom_range(0, 2) == 0);
            step(r, v, sqv, w, longint'($urandom_range(0, 7000)), c);
        end
        repeat (6) step(0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
